// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory load/store initiator (mem_access_unit).
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] WR   = 3'd2;
  localparam logic [2:0] RESP = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam int MEM_WORDS_DEFAULT = 4000;

endpackage

// File: rtl/mem_lane_align.sv
// Byte/half lane steering shared by the store merge and load extension paths.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] store_word,
  output logic [31:0] load_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    store_word = old_word;
    load_word  = old_word;
    byte_sel   = old_word[{lane, 3'b000} +: 8];
    half_sel   = old_word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        store_word[{lane, 3'b000} +: 8] = new_data[7:0];
        load_word = {{24{sign & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        store_word[{lane[1], 4'b0000} +: 16] = new_data[15:0];
        load_word = {{16{sign & half_sel[15]}}, half_sel};
      end
      SZ_WORD: store_word = new_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator to word-addressed data memory with sub-word read-modify-write.
// Optional MEM_ACCESS_CNT_EN adds successful load/store counters (ld_count, st_count).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count
`endif
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;

  logic              req_err;
  logic [ADDR_W-1:0] req_word;
  logic [31:0]       store_word;
  logic [31:0]       load_word;

  assign req_word = req_addr >> 2;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_word >= ADDR_W'(MEM_WORDS)) req_err = 1'b1;
  end

  // NOTE: reset is sampled on the clock edge; state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          size_q  <= req_size;
          sign_q  <= req_signed;
          we_q    <= req_we;
          wdata_q <= req_wdata;
          if (req_err)                            state <= ERR;
          else if (req_we && req_size == SZ_WORD) state <= WR;
          else                                    state <= RD;
        end
        RD: begin
          word_q <= mem_rdata;
          state  <= we_q ? WR : RESP;
        end
        WR:        state <= RESP;
        RESP, ERR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  mem_lane_align u_align (
    .size       (size_q),
    .lane       (addr_q[1:0]),
    .sign       (sign_q),
    .old_word   (word_q),
    .new_data   (wdata_q),
    .store_word (store_word),
    .load_word  (load_word)
  );

  // Memory strobes are gated by rst_n so an aborted cycle can never commit a write.
  assign req_ready  = (state == IDLE);
  assign mem_read   = (state == RD) & rst_n;
  assign mem_write  = (state == WR) & rst_n;
  assign mem_addr   = (state == RD || state == WR) ? (addr_q >> 2) : '0;
  assign mem_wdata  = (state == WR) ? store_word : '0;
  assign resp_valid = (state == RESP) || (state == ERR);
  assign resp_err   = (state == ERR);
  assign resp_rdata = (state == RESP && !we_q) ? load_word : '0;

`ifdef MEM_ACCESS_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_count <= '0;
      st_count <= '0;
    end else if (state == RESP) begin
      if (we_q) st_count <= st_count + 32'd1;
      else      ld_count <= ld_count + 32'd1;
    end
  end
`endif

endmodule
